// File: rtl/carregador_programa.sv
// Boot loader for nRisc: accepts a framed byte stream (sync, length, payload, checksum),
// writes the payload to instruction memory from address 0 and releases CpuReset on a good frame.
module carregador_programa #(
  parameter int                   ADDR_WIDTH = 8,
  parameter int                   DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE = 8'hA5
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] RxData,
  input  logic                  RxValid,
  output logic                  RxReady,
  output logic [ADDR_WIDTH-1:0] MemEndereco,
  output logic [DATA_WIDTH-1:0] MemDado,
  output logic                  MemWrite,
  output logic                  CpuReset,
  output logic                  Done,
  output logic                  Erro
);

  typedef enum logic [2:0] {
    ESPERA,
    TAMANHO,
    DADOS,
    CHECK,
    FIM,
    ERRO
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   rem_q, rem_d;
  logic [DATA_WIDTH-1:0]   sum_q, sum_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    rdy_q, rdy_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   maddr_q, maddr_d;
  logic [DATA_WIDTH-1:0]   mdata_q, mdata_d;
  logic [DATA_WIDTH-1:0]   chk_sum;
  logic                    accept;

  assign accept = RxValid && rdy_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ESPERA;
      rem_q   <= '0;
      sum_q   <= '0;
      addr_q  <= '0;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      mdata_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sum_q   <= sum_d;
      addr_q  <= addr_d;
      rdy_q   <= rdy_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sum_d   = sum_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    chk_sum = sum_q + RxData;
    if (accept) begin
      case (state_q)
        ESPERA, ERRO: begin
          if (RxData == SYNC_BYTE) state_d = TAMANHO;
        end
        TAMANHO: begin
          rem_d   = RxData;
          sum_d   = RxData;
          addr_d  = '0;
          state_d = (RxData == '0) ? ERRO : DADOS;
        end
        DADOS: begin
          we_d    = 1'b1;
          maddr_d = addr_q;
          mdata_d = RxData;
          sum_d   = chk_sum;
          addr_d  = addr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          if (rem_q == DATA_WIDTH'(1)) state_d = CHECK;
        end
        CHECK: begin
          state_d = (chk_sum == '0) ? FIM : ERRO;
        end
        default: state_d = state_q;
      endcase
    end
    // Ready is registered from the next state so it drops on the same edge that enters FIM.
    rdy_d = (state_d != FIM);
  end

  always_comb begin
    RxReady     = rdy_q;
    MemWrite    = we_q;
    MemEndereco = maddr_q;
    MemDado     = mdata_q;
    Done        = (state_q == FIM);
    Erro        = (state_q == ERRO);
    CpuReset    = (state_q != FIM);
  end

endmodule

// File: doc/carregador_programa.md
# carregador_programa

Boot loader for the nRisc 8-bit platform. Receives a framed byte stream over a valid/ready handshake and writes the payload into instruction memory from address 0 upward. Holds the processor in reset (CpuReset) until a complete frame with a correct checksum has been stored, then releases it. Sits directly upstream of the instruction memory and the nRisc core reset input.

## Interface

Parameters:
- ADDR_WIDTH, 8, memory address width; the address counter wraps modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 8, byte width of the stream and memory data.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- RxData  in  8  stream byte.
- RxValid  in  1  RxData is valid.
- RxReady  out  1  loader accepts a byte this cycle.
- MemEndereco  out  8  instruction memory write address.
- MemDado  out  8  instruction memory write data.
- MemWrite  out  1  one-cycle write strobe.
- CpuReset  out  1  held high until load succeeds; drives the core Reset.
- Done  out  1  load complete, checksum correct.
- Erro  out  1  frame rejected.

## Operation

- Transfer: a byte is accepted on a rising edge where RxValid=1 and RxReady=1. Nothing else counts.
- Frame format: SYNC_BYTE, length N (1..255), N payload bytes, checksum C. The frame is valid when (N + payload sum + C) mod 256 == 0.
- Payload byte k (0-based) is written to address k.
- States and behaviour:
  - ESPERA: RxReady=1. SYNC_BYTE → TAMANHO. Any other byte is discarded.
  - TAMANHO: RxReady=1. Stores N into the remaining counter, sets sum=N and address=0.
    - N=0 → ERRO.
    - Otherwise → DADOS.
  - DADOS: RxReady=1. Each accepted byte:
    - issues a write (address, byte);
    - sum += byte (8-bit wrap);
    - address++ and remaining--.
    - When the last byte is accepted → CHECK.
  - CHECK: RxReady=1. Accepted byte C:
    - (sum + C)[7:0] == 0 → FIM;
    - otherwise → ERRO.
  - FIM: RxReady=0, Done=1, CpuReset=0. Holds until Reset. Bytes are never accepted.
  - ERRO: RxReady=1, Erro=1, CpuReset=1.
    - SYNC_BYTE → TAMANHO and clears Erro.
    - Other bytes are discarded.
- A SYNC_BYTE value inside DADOS or CHECK is treated as ordinary data; there is no resynchronisation mid-frame.
- A failed frame may leave partial contents in memory. The core stays in reset, so this is harmless; a later good frame overwrites them.

## Timing

- Reset (async) values:
  - state ESPERA;
  - RxReady=0, MemWrite=0, MemEndereco=0, MemDado=0;
  - CpuReset=1, Done=0, Erro=0.
- RxReady is registered. It goes to 1 on the first rising edge after Reset deasserts.
- Write latency: MemWrite, MemEndereco and MemDado are registered. They are valid in the cycle after the accepting edge, and MemWrite is high for exactly one cycle per payload byte.
- Back-to-back bytes (RxValid held high) give one accepted byte and one write per cycle, with no bubbles.
- Done, Erro and CpuReset change on the edge after the checksum is accepted. The last MemWrite is therefore at or before the cycle in which CpuReset falls, so memory is complete before the core runs.
- In FIM, RxReady drops on the same edge that sets Done, so a byte presented immediately after C is not accepted.
- Reset asserted mid-frame aborts immediately and returns all outputs to their reset values. Any write already registered is dropped (MemWrite forced to 0).

## Test plan

- Good frame A5 03 11 22 33 97 sent back-to-back → writes (0,11), (1,22), (2,33) on consecutive cycles; Done=1 and CpuReset=0 one cycle after 97 is accepted; Erro=0.
- Bad checksum A5 03 11 22 33 98 → Erro=1, CpuReset=1, Done=0. Then A5 01 7E 81 → write (0,7E), Erro clears, Done=1.
- Garbage 00 FF 12 A4 then A5 02 05 06 F3 → garbage produces no writes; writes (0,05), (1,06); Done=1.
- Zero length A5 00 → Erro=1 after the length byte, no MemWrite; RxReady stays 1.
- Gapped RxValid (alternating 1/0) on the good frame from scenario 1 → identical writes spaced out; after Done, bytes AA BB are presented and RxReady=0, no writes, Done stays 1.
- Reset pulse after the second payload byte of scenario 1 → all outputs at reset values, including CpuReset=1. A full resend of scenario 1 completes with Done=1.
